// File: rtl/compare_serial_pkg.sv
// Shared definitions for the bit-serial magnitude comparator.
// Holds the FSM state encoding, default operand width, the internal verdict
// encoding and the verdict update function.
package compare_serial_pkg;

   localparam int unsigned DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // VERD_NONE doubles as "not yet decided"
   typedef enum logic [1:0] {
      VERD_NONE = 2'd0,
      VERD_GT   = 2'd1,
      VERD_LT   = 2'd2
   } verdict_t;

   // First differing bit pair (MSB first) fixes the verdict; later pairs cannot change it
   function automatic verdict_t verdict_next(input verdict_t cur, input logic a_bit, input logic b_bit);
      verdict_t res;
      res = cur;
      if ((cur == VERD_NONE) && (a_bit != b_bit)) begin
         res = a_bit ? VERD_GT : VERD_LT;
      end
      return res;
   endfunction

endpackage

// File: rtl/compare_serial.sv
// Bit-serial unsigned magnitude comparator, operands arrive MSB first.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : opens a new frame (aborts any open frame)
//   bit_valid        : qualifies a_bit/b_bit in SHIFT
//   a_bit, b_bit     : current operand bits
//   busy             : frame open
//   done             : one-cycle result-valid pulse
//   gt, lt, eq       : result, held until next start or reset
module compare_serial
   import compare_serial_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic bit_valid,
   input  logic a_bit,
   input  logic b_bit,
   output logic busy,
   output logic done,
   output logic gt,
   output logic lt,
   output logic eq
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   verdict_t         verd_q, verd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;
   logic             eq_q, eq_d;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         verd_q  <= VERD_NONE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gt_q    <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         verd_q  <= verd_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         gt_q    <= gt_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
      end
   end

   // Next-state, counter, verdict and result logic
   always_comb begin
      state_d = state_q;
      verd_d  = verd_q;
      cnt_d   = cnt_q;
      gt_d    = gt_q;
      lt_d    = lt_q;
      eq_d    = eq_q;

      if (start) begin
         // start wins in every state; bit_valid this cycle is ignored
         state_d = ST_SHIFT;
         verd_d  = VERD_NONE;
         cnt_d   = '0;
         gt_d    = 1'b0;
         lt_d    = 1'b0;
         eq_d    = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_SHIFT: begin
               if (bit_valid) begin
                  cnt_d  = cnt_q + CNT_W'(1);
                  verd_d = verdict_next(verd_q, a_bit, b_bit);
                  if (cnt_q == CNT_LAST) begin
                     state_d = ST_DONE;
                     gt_d    = (verd_d == VERD_GT);
                     lt_d    = (verd_d == VERD_LT);
                     eq_d    = (verd_d == VERD_NONE);
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // busy/done are registered views of the upcoming state
   always_comb begin
      busy_d = (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   assign busy = busy_q;
   assign done = done_q;
   assign gt   = gt_q;
   assign lt   = lt_q;
   assign eq   = eq_q;

endmodule
